sram_arbiter: RTL and testbench

Arbitrates one single-port 2048x32 SRAM macro between the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port). The CPU port has priority; a bounded-wait counter guarantees EXT forward progress by forcing an EXT grant and stalling the pipeline for one cycle. The block sits between the MEM stage and the data memory macro. It owns the macro's active-low CEn/WEn pins.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arbiter_starve_counter.sv | 30 +++
 rtl/sram_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and sizing for the SRAM arbiter slice.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_EXT
    } owner_e;

    localparam int SRAM_WORDS = 2048;
    localparam int ADDR_W_DEF = $clog2(SRAM_WORDS);
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/sram_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the EXT port lost arbitration.
// Only instantiated when SRAM_ARB_STARVE_EN is defined.
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAX_V) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign hit = (cnt == MAX_V);

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: CPU port has priority over EXT port.
// Define SRAM_ARB_STARVE_EN to enable the bounded-wait forced EXT grant.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    owner_e            own;
    owner_e            rd_own;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic [ADDR_W-1:0] a_hold;
    logic [DATA_W-1:0] d_hold;

`ifdef SRAM_ARB_STARVE_EN
    logic starve_hit;

    starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (ext_req & ~ext_gnt),
        .clr (ext_gnt | ~ext_req),
        .hit (starve_hit)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        own = OWN_NONE;
        if (cpu_req && ext_req) begin
            own = starve_hit ? OWN_EXT : OWN_CPU;
        end else if (cpu_req) begin
            own = OWN_CPU;
        end else if (ext_req) begin
            own = OWN_EXT;
        end
    end

    assign cpu_stall = cpu_req & (own != OWN_CPU);
`else
    logic [3:0] unused_starve_max;

    always_comb begin
        own = OWN_NONE;
        if (cpu_req) begin
            own = OWN_CPU;
        end else if (ext_req) begin
            own = OWN_EXT;
        end
    end

    assign cpu_stall         = 1'b0;
    assign unused_starve_max = 4'(STARVE_MAX);
`endif

    // Idle cycles present the held address/data so the macro bus does not toggle.
    always_comb begin
        own_we    = 1'b0;
        own_addr  = a_hold;
        own_wdata = d_hold;
        case (own)
            OWN_CPU: begin
                own_we    = cpu_we;
                own_addr  = cpu_addr;
                own_wdata = cpu_wdata;
            end
            OWN_EXT: begin
                own_we    = ext_we;
                own_addr  = ext_addr;
                own_wdata = ext_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_hold <= '0;
            d_hold <= '0;
            rd_own <= OWN_NONE;
        end else begin
            if (own != OWN_NONE) begin
                a_hold <= own_addr;
                d_hold <= own_wdata;
            end
            rd_own <= (own != OWN_NONE && !own_we) ? own : OWN_NONE;
        end
    end

    assign sram_cen   = (own == OWN_NONE);
    assign sram_wen   = (own == OWN_NONE) | ~own_we;
    assign sram_a     = own_addr;
    assign sram_d     = own_wdata;
    assign ext_gnt    = (own == OWN_EXT);
    assign cpu_rvalid = (rd_own == OWN_CPU);
    assign ext_rvalid = (rd_own == OWN_EXT);
    assign cpu_rdata  = sram_q;
    assign ext_rdata  = sram_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 2048x32 SRAM model.
// Expectations follow SRAM_ARB_STARVE_EN as defined for the build.
module tb_sram_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int SMAX = 4;

`ifdef SRAM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] mem [0:2047];

    int n_pass  = 0;
    int n_total = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic er, input logic ew,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        @(negedge clk); #1;
        n_total++;
        if ({sram_cen, sram_wen, cpu_stall, ext_gnt, cpu_rvalid, ext_rvalid} !== 6'b110000)
            $display("FAIL reset_ctrl: got %b expected 110000",
                     {sram_cen, sram_wen, cpu_stall, ext_gnt, cpu_rvalid, ext_rvalid});
        else n_pass++;
        n_total++;
        if (sram_a !== 11'h000 || sram_d !== 32'h0)
            $display("FAIL reset_bus: got a=%h d=%h expected a=000 d=00000000", sram_a, sram_d);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h010, '0, 1'b0, 1'b0, '0, '0);
        #1;
        n_total++;
        if ({sram_cen, sram_wen, cpu_stall} !== 3'b010 || sram_a !== 11'h010)
            $display("FAIL cpu_read_drive: got cen/wen/stall=%b a=%h expected 010 a=010",
                     {sram_cen, sram_wen, cpu_stall}, sram_a);
        else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++;
        if ({cpu_rvalid, ext_rvalid, cpu_stall} !== 3'b100 || cpu_rdata !== 32'hDEADBEEF)
            $display("FAIL cpu_read_data: got rv/erv/stall=%b data=%h expected 100 deadbeef",
                     {cpu_rvalid, ext_rvalid, cpu_stall}, cpu_rdata);
        else n_pass++;
        n_total++;
        if (sram_cen !== 1'b1 || sram_a !== 11'h010)
            $display("FAIL idle_hold: got cen=%b a=%h expected cen=1 a=010", sram_cen, sram_a);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (cpu_rvalid !== 1'b0)
            $display("FAIL cpu_rvalid_pulse: got %b expected 0", cpu_rvalid);
        else n_pass++;
    endtask

    task automatic test_ext_write();
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 11'h7FF, 32'h12345678);
        #1;
        n_total++;
        if ({ext_gnt, sram_cen, sram_wen, cpu_stall} !== 4'b1000 || sram_d !== 32'h12345678)
            $display("FAIL ext_write_drive: got gnt/cen/wen/stall=%b d=%h expected 1000 12345678",
                     {ext_gnt, sram_cen, sram_wen, cpu_stall}, sram_d);
        else n_pass++;
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h7FF, '0, 1'b0, 1'b0, '0, '0);
        #1;
        n_total++;
        if ({ext_rvalid, cpu_rvalid, cpu_stall} !== 3'b000)
            $display("FAIL ext_write_no_rvalid: got %b expected 000",
                     {ext_rvalid, cpu_rvalid, cpu_stall});
        else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678)
            $display("FAIL ext_write_readback: got rv=%b data=%h expected 1 12345678",
                     cpu_rvalid, cpu_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic prev_c, prev_e, exp_g;
        prev_c = 1'b0;
        prev_e = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h7FF, '0);
            #1;
            exp_g = STARVE && (k % (SMAX + 1) == 0);
            n_total++;
            if ({ext_gnt, cpu_stall} !== {exp_g, exp_g})
                $display("FAIL contend_gnt cycle %0d: got gnt/stall=%b expected %b",
                         k, {ext_gnt, cpu_stall}, {exp_g, exp_g});
            else n_pass++;
            n_total++;
            if ({cpu_rvalid, ext_rvalid} !== {prev_c, prev_e})
                $display("FAIL contend_rvalid cycle %0d: got %b expected %b",
                         k, {cpu_rvalid, ext_rvalid}, {prev_c, prev_e});
            else n_pass++;
            if (prev_e) begin
                n_total++;
                if (ext_rdata !== 32'h12345678)
                    $display("FAIL contend_ext_data cycle %0d: got %h expected 12345678", k, ext_rdata);
                else n_pass++;
            end else if (prev_c) begin
                n_total++;
                if (cpu_rdata !== 32'hDEADBEEF)
                    $display("FAIL contend_cpu_data cycle %0d: got %h expected deadbeef", k, cpu_rdata);
                else n_pass++;
            end
            prev_c = !exp_g;
            prev_e = exp_g;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h7FF, '0);
        #1;
        n_total++;
        if ({ext_gnt, cpu_stall} !== 2'b10)
            $display("FAIL cpu_drop_gnt: got gnt/stall=%b expected 10", {ext_gnt, cpu_stall});
        else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++;
        if ({ext_rvalid, cpu_rvalid} !== 2'b10 || ext_rdata !== 32'h12345678)
            $display("FAIL cpu_drop_rdata: got rv=%b data=%h expected 10 12345678",
                     {ext_rvalid, cpu_rvalid}, ext_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic exp_g;
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h7FF, '0);
        #1;
        n_total++;
        if ({ext_gnt, sram_cen} !== 2'b10)
            $display("FAIL rstmid_gnt: got gnt/cen=%b expected 10", {ext_gnt, sram_cen});
        else n_pass++;
        #2 rst = 1'b0;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++;
        if ({ext_rvalid, cpu_rvalid, sram_cen} !== 3'b001 || sram_a !== 11'h000)
            $display("FAIL rstmid_lost: got erv/crv/cen=%b a=%h expected 001 000",
                     {ext_rvalid, cpu_rvalid, sram_cen}, sram_a);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        // Build up a partial wait count, then reset with both requests still asserted.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h7FF, '0);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h7FF, '0);
            #1;
            exp_g = STARVE && (k == SMAX + 1);
            n_total++;
            if ({ext_gnt, cpu_stall} !== {exp_g, exp_g})
                $display("FAIL rstmid_wait cycle %0d: got gnt/stall=%b expected %b",
                         k, {ext_gnt, cpu_stall}, {exp_g, exp_g});
            else n_pass++;
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_starve_restart();
        logic exp_g;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h7FF, '0);
            #1;
            n_total++;
            if ({ext_gnt, cpu_stall} !== 2'b00)
                $display("FAIL restart_pre cycle %0d: got gnt/stall=%b expected 00",
                         k, {ext_gnt, cpu_stall});
            else n_pass++;
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h010, '0, 1'b0, 1'b0, 11'h7FF, '0);
        #1;
        n_total++;
        if ({ext_gnt, cpu_stall} !== 2'b00)
            $display("FAIL restart_drop: got gnt/stall=%b expected 00", {ext_gnt, cpu_stall});
        else n_pass++;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h7FF, '0);
            #1;
            exp_g = STARVE && (k == SMAX + 1);
            n_total++;
            if ({ext_gnt, cpu_stall} !== {exp_g, exp_g})
                $display("FAIL restart_wait cycle %0d: got gnt/stall=%b expected %b",
                         k, {ext_gnt, cpu_stall}, {exp_g, exp_g});
            else n_pass++;
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[16] = 32'hDEADBEEF;
        sram_q  = 32'h0;
        test_reset();
        test_cpu_read();
        test_ext_write();
        test_contention();
        test_reset_mid();
        test_starve_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
